matmul_tile_scheduler: RTL and testbench
========================================

Name: matmul_tile_scheduler

Overview:
- Sequences the matmul engine over a tiled GEMM, C[MxN] = sum over K of A·B, in units of MAT_MUL_SIZE x MAT_MUL_SIZE tiles.
- Computes the BRAM A, B and C tile addresses and drives the engine's start/done handshake, one tile at a time.
- Sits between the APB config registers and the matmul datapath.

Parameters:
- AWIDTH, 10, BRAM address width; all address arithmetic is modulo 2^AWIDTH.
- CNT_WIDTH, 8, width of the tile-count inputs and tile-index outputs.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; begin a job (sampled only in IDLE)
- cfg_abort  in  1  one-cycle pulse; abort the current job
- num_m, num_n, num_k  in  CNT_WIDTH each  tile counts per dimension
- base_a, base_b, base_c  in  AWIDTH each  base addresses
- a_m_stride, a_k_stride  in  AWIDTH each  A address step per m / per k
- b_k_stride, b_n_stride  in  AWIDTH each  B address step per k / per n
- c_m_stride, c_n_stride  in  AWIDTH each  C address step per m / per n
- mm_start  out  1  level start to the engine
- mm_done  in  1  level done from the engine
- mm_addr_a, mm_addr_b, mm_addr_c  out  AWIDTH each  tile addresses
- mm_accumulate  out  1  0 when k==0, 1 otherwise
- busy  out  1  job in progress
- done  out  1  sticky job-complete flag
- aborted  out  1  sticky; set when the last job ended by abort
- cur_m, cur_n, cur_k  out  CNT_WIDTH each  current tile indices

Behaviour:
- Reset values (asynchronous on resetn=0): all outputs 0, state IDLE. Reset mid-job drops mm_start immediately.
- Config inputs are latched on the cycle cfg_start is accepted; later changes have no effect on the running job.
- Loop order: m outermost, n middle, k innermost.
  - mm_addr_a = base_a + m*a_m_stride + k*a_k_stride
  - mm_addr_b = base_b + k*b_k_stride + n*b_n_stride
  - mm_addr_c = base_c + m*c_m_stride + n*c_n_stride
  - Addresses come from running adders (no multipliers) and wrap silently.
- IDLE:
  - On cfg_start with any count 0: done=1, aborted=0, no engine start issued, stay IDLE.
  - On cfg_start with all counts nonzero: clear done and aborted, set busy=1, index 0,0,0, go ISSUE.
- ISSUE: addresses, mm_accumulate and cur_* are valid and stable. The next cycle mm_start=1, go WAIT_DONE.
- WAIT_DONE: hold mm_start=1 and the addresses until mm_done=1 is sampled, then mm_start=0, go RELEASE.
- RELEASE: wait until mm_done=0, then go ADVANCE. This prevents a stale done from completing the next tile.
- ADVANCE: increment k.
  - k wraps to 0 and increments n; n wraps to 0 and increments m.
  - If m passes num_m-1: busy=0, done=1, go IDLE.
  - Otherwise go ISSUE.
- Latency: cfg_start at cycle t gives mm_start=1 at t+2. Each tile costs engine time + 3 cycles of overhead.
- cfg_start while busy is ignored.
- cfg_abort:
  - In ISSUE or ADVANCE: go IDLE next cycle with busy=0, aborted=1, done=1.
  - In WAIT_DONE: drop mm_start at once, then wait in RELEASE for mm_done=0 before going IDLE with busy=0, aborted=1, done=1.
  - In IDLE: ignored.
- cfg_abort and mm_done in the same cycle: abort wins; the tile is not counted.
- done stays set until the next accepted cfg_start or reset.
- Total tiles issued per job = num_m*num_n*num_k.

Test Plan:
- 1x1x1 job, bases A=0, B=0, C=0x100, engine answers done 5 cycles after start → exactly one mm_start; addresses 0/0/0x100; mm_accumulate=0; done=1 and busy=0 after release.
- num_m=2, num_n=2, num_k=2, base_a=0x10, base_b=0x40, base_c=0x80, all strides=4 → 8 tiles in order (m,n,k) = 000,001,010,011,100,...
  - Tile (1,0,1): A=0x18, B=0x44, C=0x84.
  - mm_accumulate pattern 0,1,0,1,...
- num_k=0 with cfg_start → done=1 within 1 cycle; mm_start never asserted.
- Engine holds mm_done high for 3 extra cycles after mm_start drops → next mm_start waits until mm_done=0.
- Boundary cases:
  - cfg_abort during WAIT_DONE of tile 3 → mm_start drops the next cycle; aborted=1, done=1, busy=0 once mm_done=0.
  - cfg_start while busy → ignored.
- Reset and wrap:
  - resetn pulsed low mid-job → all outputs 0 immediately; a new job runs normally afterward.
  - base_a=0x3FC, a_k_stride=8 with AWIDTH=10 → second A address is 0x004.

Source files
------------

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: walks the m/n/k tiles of a GEMM job, producing BRAM tile
// addresses with running adders and driving the engine start/done handshake.
module matmul_tile_scheduler #(
  parameter int AWIDTH = 10,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [CNT_WIDTH-1:0] num_m,
  input  logic [CNT_WIDTH-1:0] num_n,
  input  logic [CNT_WIDTH-1:0] num_k,
  input  logic [AWIDTH-1:0]    base_a,
  input  logic [AWIDTH-1:0]    base_b,
  input  logic [AWIDTH-1:0]    base_c,
  input  logic [AWIDTH-1:0]    a_m_stride,
  input  logic [AWIDTH-1:0]    a_k_stride,
  input  logic [AWIDTH-1:0]    b_k_stride,
  input  logic [AWIDTH-1:0]    b_n_stride,
  input  logic [AWIDTH-1:0]    c_m_stride,
  input  logic [AWIDTH-1:0]    c_n_stride,
  output logic                 mm_start,
  input  logic                 mm_done,
  output logic [AWIDTH-1:0]    mm_addr_a,
  output logic [AWIDTH-1:0]    mm_addr_b,
  output logic [AWIDTH-1:0]    mm_addr_c,
  output logic                 mm_accumulate,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] cur_m,
  output logic [CNT_WIDTH-1:0] cur_n,
  output logic [CNT_WIDTH-1:0] cur_k
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RELEASE, ADVANCE} state_e;
  typedef struct packed {
    state_e                state;
    logic                  done;
    logic                  aborted;
    logic                  abort_pend;
    logic [CNT_WIDTH-1:0]  m, n, k, nm, nn, nk;
    logic [AWIDTH-1:0]     base_b, a_ms, a_ks, b_ks, b_ns, c_ms, c_ns;
    logic [AWIDTH-1:0]     a_row, a, b_col, b, c_row, c;
  } regs_t;
  regs_t r_q, r_d;
  logic k_last, n_last, m_last, zero, ab;
  always_comb begin
    r_d = r_q;
    k_last = r_q.k == r_q.nk - CNT_WIDTH'(1);
    n_last = r_q.n == r_q.nn - CNT_WIDTH'(1);
    m_last = r_q.m == r_q.nm - CNT_WIDTH'(1);
    zero = (num_m == '0) || (num_n == '0) || (num_k == '0);
    ab = r_q.abort_pend | cfg_abort;
    case (r_q.state)
      IDLE: if (cfg_start) begin
        r_d.done = zero;
        r_d.aborted = 1'b0;
        if (!zero) begin
          r_d.state = ISSUE;
          r_d.abort_pend = 1'b0;
          {r_d.m, r_d.n, r_d.k} = '0;
          {r_d.nm, r_d.nn, r_d.nk} = {num_m, num_n, num_k};
          {r_d.base_b, r_d.a_ms, r_d.a_ks} = {base_b, a_m_stride, a_k_stride};
          {r_d.b_ks, r_d.b_ns, r_d.c_ms, r_d.c_ns} = {b_k_stride, b_n_stride, c_m_stride, c_n_stride};
          {r_d.a_row, r_d.a, r_d.b_col, r_d.b, r_d.c_row, r_d.c} = {base_a, base_a, base_b, base_b, base_c, base_c};
        end
      end
      ISSUE: begin
        r_d.state = cfg_abort ? IDLE : WAIT_DONE;
        r_d.done = cfg_abort;
        r_d.aborted = cfg_abort;
      end
      WAIT_DONE: if (cfg_abort || mm_done) begin
        r_d.state = RELEASE;
        r_d.abort_pend = cfg_abort;
      end
      // a done still high from the last tile must clear before the next issue
      RELEASE: begin
        r_d.abort_pend = ab & mm_done;
        if (!mm_done) begin
          r_d.state = ab ? IDLE : ADVANCE;
          r_d.done = ab;
          r_d.aborted = ab;
        end
      end
      ADVANCE: if (cfg_abort || (k_last && n_last && m_last)) begin
        r_d.state = IDLE;
        r_d.done = 1'b1;
        r_d.aborted = cfg_abort;
      end else begin
        r_d.state = ISSUE;
        if (!k_last) begin
          r_d.k = r_q.k + CNT_WIDTH'(1);
          r_d.a = r_q.a + r_q.a_ks;
          r_d.b = r_q.b + r_q.b_ks;
        end else if (!n_last) begin
          r_d.k = '0;
          r_d.n = r_q.n + CNT_WIDTH'(1);
          r_d.a = r_q.a_row;
          r_d.b_col = r_q.b_col + r_q.b_ns;
          r_d.b = r_q.b_col + r_q.b_ns;
          r_d.c = r_q.c + r_q.c_ns;
        end else begin
          {r_d.k, r_d.n} = '0;
          r_d.m = r_q.m + CNT_WIDTH'(1);
          r_d.a_row = r_q.a_row + r_q.a_ms;
          r_d.a = r_q.a_row + r_q.a_ms;
          r_d.b_col = r_q.base_b;
          r_d.b = r_q.base_b;
          r_d.c_row = r_q.c_row + r_q.c_ms;
          r_d.c = r_q.c_row + r_q.c_ms;
        end
      end
      default: r_d.state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_q <= '0;
    else r_q <= r_d;
  end
  assign mm_start = r_q.state == WAIT_DONE;
  assign busy = r_q.state != IDLE;
  assign done = r_q.done;
  assign aborted = r_q.aborted;
  assign mm_addr_a = r_q.a;
  assign mm_addr_b = r_q.b;
  assign mm_addr_c = r_q.c;
  assign mm_accumulate = r_q.k != '0;
  assign cur_m = r_q.m;
  assign cur_n = r_q.n;
  assign cur_k = r_q.k;
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb_matmul_tile_scheduler: directed and randomized jobs against a loop-nest model of
// the tile sequence, with a behavioural engine answering the start/done handshake.
module tb_matmul_tile_scheduler;
  localparam int AW = 10;
  localparam int CW = 8;
  logic clk = 1'b0, resetn = 1'b0, cfg_start = 1'b0, cfg_abort = 1'b0, mm_done = 1'b0;
  logic [CW-1:0] num_m, num_n, num_k, cur_m, cur_n, cur_k;
  logic [AW-1:0] base_a, base_b, base_c, a_m_stride, a_k_stride, b_k_stride, b_n_stride;
  logic [AW-1:0] c_m_stride, c_n_stride, mm_addr_a, mm_addr_b, mm_addr_c;
  logic mm_start, mm_accumulate, busy, done, aborted;
  typedef struct packed {
    logic [AW-1:0] a, b, c;
    logic [CW-1:0] m, n, k;
    logic acc;
  } tile_t;
  tile_t exp_q[$], log_q[$];
  int checks = 0, errors = 0, tiles_seen = 0, eng_lat = 1, eng_hold = 0;

  matmul_tile_scheduler #(.AWIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .num_m(num_m), .num_n(num_n), .num_k(num_k),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .a_m_stride(a_m_stride), .a_k_stride(a_k_stride), .b_k_stride(b_k_stride),
    .b_n_stride(b_n_stride), .c_m_stride(c_m_stride), .c_n_stride(c_n_stride),
    .mm_start(mm_start), .mm_done(mm_done), .mm_addr_a(mm_addr_a), .mm_addr_b(mm_addr_b),
    .mm_addr_c(mm_addr_c), .mm_accumulate(mm_accumulate), .busy(busy), .done(done),
    .aborted(aborted), .cur_m(cur_m), .cur_n(cur_n), .cur_k(cur_k)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int m, n, k, ba, bb, bc, ams, aks, bks, bns, cms, cns);
    {num_m, num_n, num_k} = {CW'(m), CW'(n), CW'(k)};
    {base_a, base_b, base_c} = {AW'(ba), AW'(bb), AW'(bc)};
    {a_m_stride, a_k_stride, b_k_stride} = {AW'(ams), AW'(aks), AW'(bks)};
    {b_n_stride, c_m_stride, c_n_stride} = {AW'(bns), AW'(cms), AW'(cns)};
  endtask

  task automatic set_random_cfg();
    set_cfg($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
            int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom),
            int'($urandom), int'($urandom), int'($urandom), int'($urandom));
  endtask

  // Expected tile stream from the GEMM loop nest, m outer, k inner
  task automatic build_model();
    tile_t e;
    exp_q.delete();
    for (int m = 0; m < int'(num_m); m++)
      for (int n = 0; n < int'(num_n); n++)
        for (int k = 0; k < int'(num_k); k++) begin
          e.a = AW'(int'(base_a) + m * int'(a_m_stride) + k * int'(a_k_stride));
          e.b = AW'(int'(base_b) + k * int'(b_k_stride) + n * int'(b_n_stride));
          e.c = AW'(int'(base_c) + m * int'(c_m_stride) + n * int'(c_n_stride));
          {e.m, e.n, e.k} = {CW'(m), CW'(n), CW'(k)};
          e.acc = k != 0;
          exp_q.push_back(e);
        end
  endtask

  // Engine: answers each start after eng_lat cycles, holds done eng_hold extra cycles
  initial begin
    bit act, prev;
    int cnt, hcnt;
    tile_t t;
    act = 0; prev = 0; cnt = 0; hcnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mm_done = 1'b0; act = 0; prev = 0;
      end else begin
        if (mm_start && !prev) begin
          chk("start_while_done", 64'(mm_done), 64'(0));
          t = {mm_addr_a, mm_addr_b, mm_addr_c, cur_m, cur_n, cur_k, mm_accumulate};
          log_q.push_back(t);
          tiles_seen++;
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL extra_tile observed tile %0d expected none", tiles_seen);
          end
          if (exp_q.size() != 0) chk("tile", 64'(t), 64'(exp_q.pop_front()));
          act = 1; cnt = eng_lat;
        end else if (act) begin
          if (!mm_start) act = 0;
          else begin
            cnt--;
            if (cnt <= 0) begin mm_done = 1'b1; act = 0; hcnt = eng_hold; end
          end
        end else if (mm_done && !mm_start) begin
          if (hcnt == 0) mm_done = 1'b0;
          else hcnt--;
        end
        prev = mm_start;
      end
    end
  end

  task automatic wait_tiles(input int n);
    for (int i = 0; i < 3000 && tiles_seen < n; i++) @(negedge clk);
    chk("tiles_reached", 64'(tiles_seen >= n), 64'(1));
  endtask

  // mode 0 plain, 1 cfg_start+config change mid-job, 2 abort after arg tiles, 3 reset after arg tiles
  task automatic run_job(input int lat, hold, mode, arg);
    int exp_n;
    exp_n = int'(num_m) * int'(num_n) * int'(num_k);
    build_model();
    log_q.delete();
    tiles_seen = 0; eng_lat = lat; eng_hold = hold;
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("done_cleared", 64'(done), 64'(0));
    chk("start_lat1", 64'(mm_start), 64'(0));
    @(negedge clk);
    chk("start_lat2", 64'(mm_start), 64'(1));
    if (mode == 1) begin
      wait_tiles(arg);
      @(posedge clk); #1;
      set_random_cfg();
      cfg_start = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
    end else if (mode == 2) begin
      wait_tiles(arg);
      cfg_abort = 1'b1;
      @(posedge clk); #1 cfg_abort = 1'b0;
      @(negedge clk);
      chk("abort_drop", 64'(mm_start), 64'(0));
      exp_n = arg;
    end else if (mode == 3) begin
      wait_tiles(arg);
      @(posedge clk); #2 resetn = 1'b0;
      #1 chk("async_reset_outputs", 64'({mm_start, busy, done, aborted, mm_addr_a, mm_addr_b,
             mm_addr_c, cur_m, cur_n, cur_k, mm_accumulate}), 64'(0));
      repeat (2) @(negedge clk);
      @(posedge clk); #1 resetn = 1'b1;
      return;
    end
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    chk("job_end_busy", 64'(busy), 64'(0));
    chk("job_end_done", 64'(done), 64'(1));
    chk("job_end_aborted", 64'(aborted), 64'(mode == 2));
    chk("tile_count", 64'(tiles_seen), 64'(exp_n));
    repeat (3) @(negedge clk);
    chk("done_sticky", 64'(done), 64'(1));
  endtask

  initial begin
    set_cfg(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({mm_start, busy, done, aborted, mm_addr_a, mm_addr_b, mm_addr_c,
        cur_m, cur_n, cur_k, mm_accumulate}), 64'(0));
    @(posedge clk); #1 resetn = 1'b1;

    set_cfg(1, 1, 1, 'h0, 'h0, 'h100, 4, 4, 4, 4, 4, 4);
    run_job(5, 0, 0, 0);
    chk("t1_addr", 64'({log_q[0].a, log_q[0].b, log_q[0].c}), 64'({10'h0, 10'h0, 10'h100}));
    chk("t1_acc", 64'(log_q[0].acc), 64'(0));

    set_cfg(2, 2, 2, 'h10, 'h40, 'h80, 4, 4, 4, 4, 4, 4);
    run_job(3, 0, 0, 0);
    chk("t2_tile101", 64'({log_q[5].a, log_q[5].b, log_q[5].c}), 64'({10'h18, 10'h44, 10'h84}));
    for (int i = 0; i < 8; i++) chk("t2_acc", 64'(log_q[i].acc), 64'(i % 2));

    set_cfg(1, 1, 2, 'h20, 'h30, 'h40, 1, 2, 3, 4, 5, 6);
    run_job(2, 3, 0, 0);

    set_cfg(2, 2, 2, 'h10, 'h40, 'h80, 4, 4, 4, 4, 4, 4);
    run_job(6, 1, 2, 4);

    @(posedge clk); #1 cfg_abort = 1'b1;
    @(posedge clk); #1 cfg_abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", 64'({busy, done, aborted}), 64'({1'b0, 1'b1, 1'b1}));

    set_cfg(2, 2, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9);
    tiles_seen = 0;
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    @(negedge clk);
    chk("zero_count_flags", 64'({busy, done, aborted}), 64'({1'b0, 1'b1, 1'b0}));
    repeat (5) @(negedge clk);
    chk("zero_count_no_tiles", 64'(tiles_seen), 64'(0));

    set_cfg(1, 1, 2, 'h3FC, 0, 0, 0, 8, 0, 0, 0, 0);
    run_job(2, 0, 0, 0);
    chk("wrap_addr_a", 64'(log_q[1].a), 64'(10'h004));

    for (int i = 0; i < 8; i++) begin
      set_random_cfg();
      run_job($urandom_range(2, 6), $urandom_range(0, 3), i % 2, 1);
    end

    set_random_cfg();
    num_k = 3;
    run_job(4, 1, 3, 2);
    set_random_cfg();
    run_job(3, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
